dcache_mem_stage: RTL and testbench

DCACHE_MEM_STAGE -- requirements
Module: dcache_mem_stage

---
 rtl/dcache_mem_stage.sv | 131 +++++++++++++
 tb/tb_dcache_mem_stage.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_mem_stage.sv
// Memory-stage data cache: direct-mapped, write-through, no-write-allocate, 4 words per line.
// Misses stall the pipeline while a 4-beat fill or a single write-through runs on main memory.
module dcache_mem_stage #(
    parameter int INDEX_BITS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [31:0] ALUoutM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] Mem_RDM,
    output logic        Mem_Stall,
    output logic        mm_req,
    output logic        mm_we,
    output logic [31:0] mm_addr,
    output logic [31:0] mm_wdata,
    input  logic [31:0] mm_rdata,
    input  logic        mm_ack
);

    localparam int TAG_BITS = 32 - INDEX_BITS - 4;
    localparam int LINES    = 1 << INDEX_BITS;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        WRITE
    } state_t;

    state_t              state_q;
    logic [1:0]          cnt_q;
    logic [LINES-1:0]    valid_q;
    logic [TAG_BITS-1:0] tag_q  [LINES];
    logic [31:0]         data_q [LINES][4];

    logic [1:0]            word;
    logic [INDEX_BITS-1:0] index;
    logic [TAG_BITS-1:0]   tag;
    logic                  hit;
    logic                  fill_we;
    logic                  fill_last;
    logic                  write_hit_we;
    logic                  unused_byte_bits;

    assign word             = ALUoutM[3:2];
    assign index            = ALUoutM[INDEX_BITS+3:4];
    assign tag              = ALUoutM[31:INDEX_BITS+4];
    assign unused_byte_bits = ^ALUoutM[1:0];

    assign hit          = valid_q[index] && (tag_q[index] == tag);
    assign fill_we      = (state_q == FILL) && mm_ack;
    assign fill_last    = fill_we && (cnt_q == 2'd3);
    assign write_hit_we = (state_q == WRITE) && mm_ack && hit;

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        Mem_Stall = 1'b0;
        Mem_RDM   = '0;
        mm_req    = 1'b0;
        mm_we     = 1'b0;
        mm_addr   = '0;
        mm_wdata  = '0;
        case (state_q)
            IDLE: begin
                if (MemWriteM) begin
                    Mem_Stall = 1'b1;
                end else if (MemReadM) begin
                    if (hit) Mem_RDM = data_q[index][word];
                    else     Mem_Stall = 1'b1;
                end
            end
            FILL: begin
                mm_req    = 1'b1;
                mm_addr   = {tag, index, cnt_q, 2'b00};
                Mem_Stall = 1'b1;
            end
            WRITE: begin
                mm_req    = 1'b1;
                mm_we     = 1'b1;
                mm_addr   = {ALUoutM[31:2], 2'b00};
                mm_wdata  = WriteDataM;
                Mem_Stall = !mm_ack;
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            valid_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (MemWriteM) begin
                        state_q <= WRITE;
                    end else if (MemReadM && !hit) begin
                        // The victim line is invalid until its last beat lands.
                        valid_q[index] <= 1'b0;
                        cnt_q          <= 2'd0;
                        state_q        <= FILL;
                    end
                end
                FILL: begin
                    if (mm_ack) begin
                        cnt_q <= cnt_q + 2'd1;
                        if (cnt_q == 2'd3) begin
                            valid_q[index] <= 1'b1;
                            state_q        <= IDLE;
                        end
                    end
                end
                WRITE: begin
                    if (mm_ack) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // NOTE: tag and data arrays carry no reset; the valid bits alone decide whether they are used.
    always_ff @(posedge clk) begin
        if (fill_we)      data_q[index][cnt_q] <= mm_rdata;
        if (fill_last)    tag_q[index]         <= tag;
        if (write_hit_we) data_q[index][word]  <= WriteDataM;
    end

endmodule

// File: tb/tb_dcache_mem_stage.sv
// Directed and randomized bench for dcache_mem_stage against a backing-memory and line-presence model.
module tb_dcache_mem_stage;

    localparam int IB    = 4;
    localparam int LINES = 1 << IB;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemReadM, MemWriteM;
    logic [31:0] ALUoutM, WriteDataM;
    logic [31:0] Mem_RDM;
    logic        Mem_Stall;
    logic        mm_req, mm_we;
    logic [31:0] mm_addr, mm_wdata;
    logic [31:0] mm_rdata;
    logic        mm_ack;

    always #5 clk = ~clk;

    dcache_mem_stage #(.INDEX_BITS(IB)) dut (
        .clk        (clk),
        .rst        (rst),
        .MemReadM   (MemReadM),
        .MemWriteM  (MemWriteM),
        .ALUoutM    (ALUoutM),
        .WriteDataM (WriteDataM),
        .Mem_RDM    (Mem_RDM),
        .Mem_Stall  (Mem_Stall),
        .mm_req     (mm_req),
        .mm_we      (mm_we),
        .mm_addr    (mm_addr),
        .mm_wdata   (mm_wdata),
        .mm_rdata   (mm_rdata),
        .mm_ack     (mm_ack)
    );

    int checks   = 0;
    int failures = 0;

    // Backing store: untouched words read as addr ^ A5A5A5A5.
    logic [31:0] mem [logic [31:0]];
    // Which memory line each cache slot currently mirrors (write-through keeps data equal to mem).
    bit          m_valid [LINES];
    logic [31:0] m_tag   [LINES];

    logic [31:0] rd_q[$];
    logic [31:0] wa_q[$];
    logic [31:0] wd_q[$];
    int          wait_n;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : (a ^ 32'hA5A5_A5A5);
    endfunction

    // Main memory: acknowledges a request after lat idle cycles, in the same cycle it decides.
    task automatic respond(input int lat);
        if (mm_req) begin
            if (wait_n >= lat) begin
                mm_ack = 1'b1;
                wait_n = 0;
                if (mm_we) begin
                    wa_q.push_back(mm_addr);
                    wd_q.push_back(mm_wdata);
                    mem[mm_addr] = mm_wdata;
                    mm_rdata = $urandom;
                end else begin
                    rd_q.push_back(mm_addr);
                    mm_rdata = mem_rd(mm_addr);
                end
            end else begin
                mm_ack   = 1'b0;
                wait_n++;
                mm_rdata = $urandom;
            end
        end else begin
            mm_ack   = 1'b0;
            wait_n   = 0;
            mm_rdata = $urandom;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle(input int lat);
        #1;
        respond(lat);
        #1;
    endtask

    task automatic clear_log();
        rd_q.delete();
        wa_q.delete();
        wd_q.delete();
    endtask

    task automatic do_load(input logic [31:0] a, input int lat);
        int          stalls, done, exp_stalls;
        logic [31:0] got, req_seen;
        logic [IB-1:0] idx;
        logic [31:0] tg;
        bit          exp_hit;
        idx     = a[IB+3:4];
        tg      = 32'(a[31:IB+4]);
        exp_hit = m_valid[idx] && (m_tag[idx] == tg);
        exp_stalls = exp_hit ? 0 : 1 + 4 * (1 + lat);
        clear_log();
        MemReadM = 1'b1; MemWriteM = 1'b0; ALUoutM = a; WriteDataM = $urandom;
        stalls = 0; done = 0; got = '0; req_seen = '1;
        for (int c = 0; c < 200; c++) begin
            settle(lat);
            if (!Mem_Stall) begin
                done = 1; got = Mem_RDM; req_seen = 32'(mm_req);
                break;
            end
            stalls++;
            step();
        end
        check("load_done", 32'(done), 32'd1);
        check("load_data", got, mem_rd({a[31:2], 2'b00}));
        check("load_stall_cycles", 32'(stalls), 32'(exp_stalls));
        check("load_req_when_served", req_seen, 32'd0);
        check("load_fill_beats", 32'(rd_q.size()), exp_hit ? 32'd0 : 32'd4);
        check("load_mem_writes", 32'(wa_q.size()), 32'd0);
        if (!exp_hit) begin
            for (int k = 0; k < 4; k++) begin
                logic [31:0] obs;
                obs = (k < rd_q.size()) ? rd_q[k] : 32'hFFFF_FFFF;
                check("fill_addr", obs, {a[31:4], 4'(k * 4)});
            end
        end
        m_valid[idx] = 1'b1;
        m_tag[idx]   = tg;
        step();
        MemReadM = 1'b0;
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d, input int lat, input logic both);
        int          stalls, done;
        logic [31:0] we_seen, wd_seen, wa_seen;
        clear_log();
        MemWriteM = 1'b1; MemReadM = both; ALUoutM = a; WriteDataM = d;
        stalls = 0; done = 0; we_seen = '0; wd_seen = '0; wa_seen = '0;
        for (int c = 0; c < 200; c++) begin
            settle(lat);
            if (!Mem_Stall) begin
                done = 1; we_seen = 32'(mm_we); wd_seen = mm_wdata; wa_seen = mm_addr;
                break;
            end
            stalls++;
            step();
        end
        check("store_done", 32'(done), 32'd1);
        check("store_stall_cycles", 32'(stalls), 32'(1 + lat));
        check("store_we_at_ack", we_seen, 32'd1);
        check("store_wdata", wd_seen, d);
        check("store_addr", wa_seen, {a[31:2], 2'b00});
        check("store_mem_writes", 32'(wa_q.size()), 32'd1);
        check("store_fill_beats", 32'(rd_q.size()), 32'd0);
        step();
        MemWriteM = 1'b0; MemReadM = 1'b0;
    endtask

    initial begin
        int acks;
        rst = 1'b1; MemReadM = 1'b0; MemWriteM = 1'b0; ALUoutM = '0; WriteDataM = '0;
        mm_ack = 1'b0; mm_rdata = '0; wait_n = 0;
        for (int i = 0; i < LINES; i++) begin
            m_valid[i] = 1'b0; m_tag[i] = '0;
        end

        // Reset with nothing pending
        @(posedge clk); #2;
        @(posedge clk); #2;
        check("rst_stall", 32'(Mem_Stall), 32'd0);
        check("rst_rdm", Mem_RDM, 32'd0);
        check("rst_req", 32'(mm_req), 32'd0);
        step();
        rst = 1'b0;
        settle(0);
        check("idle_stall", 32'(Mem_Stall), 32'd0);
        check("idle_rdm", Mem_RDM, 32'd0);
        check("idle_req", 32'(mm_req), 32'd0);
        check("idle_addr", mm_addr, 32'd0);
        step();

        // Cold miss, hit, write hit, read-after-write hit
        do_load(32'h0000_0104, 0);
        do_load(32'h0000_0108, 0);
        do_store(32'h0000_0104, 32'hDEAD_BEEF, 3, 1'b0);
        do_load(32'h0000_0104, 0);

        // Conflict miss then a store miss that must not touch the line
        do_load(32'h0000_1104, 0);
        do_store(32'h0000_2000, 32'h1234_5678, 1, 1'b0);
        do_load(32'h0000_1100, 0);
        do_load(32'h0000_2000, 1);

        // Read and write together behave as a write only
        do_store(32'h0000_0208, 32'hCAFE_F00D, 0, 1'b1);
        do_load(32'h0000_0208, 0);

        // Reset after the second fill beat
        clear_log();
        MemReadM = 1'b1; ALUoutM = 32'h0000_3148;
        acks = 0;
        for (int c = 0; c < 50; c++) begin
            settle(0);
            if (mm_ack) acks++;
            if (acks == 2) break;
            step();
        end
        check("midfill_acks", 32'(acks), 32'd2);
        step();
        rst = 1'b1; mm_ack = 1'b0;
        #2;
        step();
        rst = 1'b0; MemReadM = 1'b0; mm_ack = 1'b0; wait_n = 0;
        for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
        #2;
        check("post_rst_req", 32'(mm_req), 32'd0);
        check("post_rst_stall", 32'(Mem_Stall), 32'd0);
        check("post_rst_rdm", Mem_RDM, 32'd0);
        step();
        do_load(32'h0000_3148, 0);

        // Randomized traffic over a few indices and tags
        for (int n = 0; n < 40; n++) begin
            logic [31:0] a;
            int op, lat;
            a   = {$urandom_range(0, 2) << (IB + 4)} | 32'($urandom_range(0, 3) << 4) | 32'($urandom_range(0, 15));
            op  = $urandom_range(0, 3);
            lat = $urandom_range(0, 2);
            if (op < 2) do_load(a, lat);
            else        do_store(a, $urandom, lat, op == 3);
        end

        settle(0);
        check("final_idle_stall", 32'(Mem_Stall), 32'd0);
        check("final_idle_rdm", Mem_RDM, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
